// File: rtl/neuron_mac_if.sv
// Bus bundle for neuron_mac: weight-load port, sample stream and result.
// Handshake: in_valid marks in_data as present for the edge it is sampled on;
// there is no ready, every valid sample is consumed. out_valid is a one-cycle
// strobe qualifying sig_x. busy reports a partially accumulated vector.
interface neuron_mac_if #(
  parameter int NUM_WEIGHTS  = 784,
  parameter int DATA_WIDTH   = 16,
  parameter int SIG_IN_WIDTH = 10
);
  localparam int ADDR_WIDTH = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

  logic                           wr_en;
  logic        [ADDR_WIDTH-1:0]   wr_addr;
  logic signed [DATA_WIDTH-1:0]   wr_data;
  logic signed [DATA_WIDTH-1:0]   bias;
  logic                           in_valid;
  logic signed [DATA_WIDTH-1:0]   in_data;
  logic signed [SIG_IN_WIDTH-1:0] sig_x;
  logic                           out_valid;
  logic                           busy;

  // Driver side (system / testbench)
  modport master (
    output wr_en, wr_addr, wr_data, bias, in_valid, in_data,
    input  sig_x, out_valid, busy
  );

  // Neuron side
  modport slave (
    input  wr_en, wr_addr, wr_data, bias, in_valid, in_data,
    output sig_x, out_valid, busy
  );
endinterface

// File: rtl/neuron_mac.sv
// Single neuron: streams NUM_WEIGHTS signed samples, multiplies each by its
// stored weight, accumulates with saturation, adds the bias and produces a
// saturated, scaled address for the sigmoid ROM two edges after the last
// sample of a vector.
module neuron_mac #(
  parameter int NUM_WEIGHTS  = 784,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC         = 8,
  parameter int SIG_IN_WIDTH = 10,
  parameter int SUM_SHIFT    = 11
) (
  input  logic       clk,
  input  logic       rst,
  neuron_mac_if.slave bus,
  output logic [1:0] state_dbg
);

  localparam int AW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WEIGHTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Clamp a wide sum back into the PW-bit signed accumulator range.
  function automatic logic signed [PW-1:0] sat_pw(input logic signed [PW+1:0] v);
    if ((&v[PW+1:PW-1]) || (~|v[PW+1:PW-1])) return v[PW-1:0];
    else if (v[PW+1])                        return {1'b1, {(PW-1){1'b0}}};
    else                                     return {1'b0, {(PW-1){1'b1}}};
  endfunction

  // Clamp the scaled sum into the SIG_IN_WIDTH signed ROM address range.
  function automatic logic signed [SIG_IN_WIDTH-1:0] sat_sig(input logic signed [PW-1:0] v);
    if ((&v[PW-1:SIG_IN_WIDTH-1]) || (~|v[PW-1:SIG_IN_WIDTH-1])) return v[SIG_IN_WIDTH-1:0];
    else if (v[PW-1]) return {1'b1, {(SIG_IN_WIDTH-1){1'b0}}};
    else              return {1'b0, {(SIG_IN_WIDTH-1){1'b1}}};
  endfunction

  logic signed [DATA_WIDTH-1:0]   w_mem [NUM_WEIGHTS];
  logic signed [DATA_WIDTH-1:0]   w_rd;

  state_t                         state_q, state_d;
  logic        [AW-1:0]           cnt_q, cnt_d;
  logic signed [PW-1:0]           prod_q, prod_d;
  logic                           prod_vld_q, prod_vld_d;
  logic                           prod_last_q, prod_last_d;
  logic signed [PW-1:0]           acc_q, acc_d;
  logic signed [SIG_IN_WIDTH-1:0] sig_x_q, sig_x_d;
  logic                           out_valid_q, out_valid_d;

  logic                           accept;
  logic                           is_last_in;
  logic                           busy;
  logic signed [PW+1:0]           acc_ext, prod_ext, bias_ext;
  logic signed [PW-1:0]           acc_sum, final_sum, final_shifted;

  assign w_rd       = w_mem[cnt_q];
  assign accept     = bus.in_valid;
  assign is_last_in = (cnt_q == LAST_IDX);

  // Weight storage: writable only when no vector is in progress; not reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en && !busy) begin
      w_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Datapath next-state: stage 1 multiply, stage 2 accumulate / finalise.
  always_comb begin
    cnt_d         = cnt_q;
    prod_d        = prod_q;
    prod_vld_d    = accept;
    prod_last_d   = accept && is_last_in;
    acc_d         = acc_q;
    sig_x_d       = sig_x_q;
    out_valid_d   = 1'b0;

    acc_ext       = {{2{acc_q[PW-1]}}, acc_q};
    prod_ext      = {{2{prod_q[PW-1]}}, prod_q};
    bias_ext      = {{(PW+2-DATA_WIDTH){bus.bias[DATA_WIDTH-1]}}, bus.bias} <<< FRAC;
    acc_sum       = sat_pw(acc_ext + prod_ext);
    final_sum     = sat_pw(acc_ext + prod_ext + bias_ext);
    final_shifted = final_sum >>> SUM_SHIFT;

    if (accept) begin
      prod_d = PW'($signed(bus.in_data)) * PW'($signed(w_rd));
      cnt_d  = is_last_in ? '0 : cnt_q + 1'b1;
    end

    if (prod_vld_q) begin
      if (prod_last_q) begin
        sig_x_d     = sat_sig(final_shifted);
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Control FSM next-state: tracks whether a vector is partly accumulated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) state_d = is_last_in ? S_FLUSH : S_ACCUM;
      end
      S_FLUSH: begin
        if (accept) state_d = is_last_in ? S_FLUSH : S_ACCUM;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control FSM outputs.
  always_comb begin
    busy      = (state_q != S_IDLE);
    state_dbg = state_q;
  end

  // State register: reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
      acc_q       <= '0;
      sig_x_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      prod_last_q <= prod_last_d;
      acc_q       <= acc_d;
      sig_x_q     <= sig_x_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sig_x     = sig_x_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_neuron_mac.sv
// Testbench for neuron_mac with four weights: fixed vector table, hand-built
// latency / back-to-back / reset sequences and randomized vectors checked
// against an arithmetic reference model.
module tb_neuron_mac;

  localparam int NW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  neuron_mac_if #(.NUM_WEIGHTS(NW), .DATA_WIDTH(16), .SIG_IN_WIDTH(10)) bus ();

  neuron_mac #(.NUM_WEIGHTS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [NW-1:0][15:0] w;
    logic [15:0]         b;
    logic [NW-1:0][15:0] x;
    logic [9:0]          exp;
    string               name;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every out_valid pulse is matched to the next expected result.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      chk("out_valid_single_cycle", {31'b0, prev_ov}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_result_pending", exp_q.size(), 32'd1);
      else                   chk("sig_x", {22'b0, bus.sig_x}, {22'b0, exp_q.pop_front()});
    end
    prev_ov <= bus.out_valid;
  end

  // Reference model: spec arithmetic on plain integers.
  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [9:0] ref_sig(input logic [NW-1:0][15:0] w, input logic [15:0] b,
                                         input logic [NW-1:0][15:0] x);
    longint acc, p, s;
    acc = 0;
    s   = 0;
    for (int i = 0; i < NW; i++) begin
      p = longint'($signed(x[i])) * longint'($signed(w[i]));
      if (i < NW - 1) acc = sat32(acc + p);
      else            s   = sat32(acc + p + longint'($signed(b)) * 256);
    end
    s = s >>> 11;
    if (s > 511)  s = 511;
    if (s < -512) s = -512;
    return s[9:0];
  endfunction

  function automatic logic [15:0] rnd(input int mag);
    int v;
    if (mag >= 32768) v = int'($urandom_range(0, 65535));
    else              v = int'($urandom_range(0, 2 * mag - 1)) - mag;
    return v[15:0];
  endfunction

  // Driver tasks
  task automatic write_w(input int idx, input logic [15:0] val);
    bus.wr_en   = 1'b1;
    bus.wr_addr = idx[1:0];
    bus.wr_data = val;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  bit tr_started, tr_ov, tr_busy_bad;

  task automatic step();
    tick();
    if (tr_started && !tr_ov) begin
      if (bus.out_valid) begin
        tr_ov = 1'b1;
        chk("busy_low_at_out_valid", {31'b0, bus.busy}, 32'd0);
      end else if (!bus.busy) begin
        tr_busy_bad = 1'b1;
      end
    end
  endtask

  task automatic run_vec(input logic [NW-1:0][15:0] w, input logic [15:0] b,
                         input logic [NW-1:0][15:0] x, input int gap_max,
                         input logic [9:0] exp, input string name);
    int ng;
    for (int i = 0; i < NW; i++) write_w(i, w[i]);
    bus.bias    = b;
    exp_q.push_back(exp);
    tr_started  = 1'b0;
    tr_ov       = 1'b0;
    tr_busy_bad = 1'b0;
    for (int i = 0; i < NW; i++) begin
      ng = (gap_max > 0 && i > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < ng; g++) begin
        bus.in_valid = 1'b0;
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = x[i];
      tr_started   = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 10; t++) if (!tr_ov) step();
    chk({name, "_out_valid_seen"}, {31'b0, tr_ov}, 32'd1);
    chk({name, "_busy_held_until_out"}, {31'b0, tr_busy_bad}, 32'd0);
    tick();
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 20; t++) if (exp_q.size() != 0) tick();
    tick();
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [NW-1:0][15:0] rw, rx;
  logic [15:0]         rb;
  logic [9:0]          rexp;
  int                  mag;

  initial begin
    tbl[0] = '{w: {4{16'h0100}}, b: 16'h0000, x: {4{16'h0100}}, exp: 10'h080, name: "ones"};
    tbl[1] = '{w: {4{16'h0100}}, b: 16'h0000, x: {4{16'hFF00}}, exp: 10'h380, name: "minus_ones"};
    tbl[2] = '{w: {4{16'h7FFF}}, b: 16'h0000, x: {4{16'h7FFF}}, exp: 10'h1FF, name: "pos_sat"};
    tbl[3] = '{w: {4{16'h8000}}, b: 16'h0000, x: {4{16'h7FFF}}, exp: 10'h200, name: "neg_sat"};
    tbl[4] = '{w: {4{16'h0000}}, b: 16'h0080,
               x: {16'hABCD, 16'h8000, 16'h7FFF, 16'h1234}, exp: 10'h010, name: "bias_only"};
    tbl[5] = '{w: {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, b: 16'h0000,
               x: {16'h0400, 16'h0100, 16'h0100, 16'h0200}, exp: 10'h0A0, name: "mixed"};
    tbl[6] = '{w: {4{16'h0100}}, b: 16'hFF80, x: {4{16'h0100}}, exp: 10'h070, name: "neg_bias"};

    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.bias     = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_sig_x", {22'b0, bus.sig_x}, 32'd0);
    chk("reset_state", {30'b0, state_dbg}, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 7; i++)
      run_vec(tbl[i].w, tbl[i].b, tbl[i].x, 0, tbl[i].exp, tbl[i].name);

    // Latency and hold: weights are 1.0 from the last table entry; bias 0.
    bus.bias = 16'h0000;
    exp_q.push_back(10'h080);
    for (int i = 0; i < NW; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0100;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("lat_edgeE_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("lat_edgeE_busy", {31'b0, bus.busy}, 32'd1);
    chk("lat_edgeE_state_flush", {30'b0, state_dbg}, 32'd2);
    tick();
    chk("lat_edgeE1_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("lat_edgeE1_sig_x", {22'b0, bus.sig_x}, 32'h080);
    chk("lat_edgeE1_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    chk("lat_edgeE2_out_valid", {31'b0, bus.out_valid}, 32'd0);
    tick();
    tick();
    chk("sig_x_hold", {22'b0, bus.sig_x}, 32'h080);
    drain("latency");

    // Back-to-back vectors: 1.0s then -1.0s with no idle cycle.
    exp_q.push_back(10'h080);
    exp_q.push_back(10'h380);
    for (int i = 0; i < 2 * NW; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i < NW) ? 16'h0100 : 16'hFF00;
      tick();
      if (i == NW) chk("b2b_state_accum", {30'b0, state_dbg}, 32'd1);
    end
    bus.in_valid = 1'b0;
    drain("back_to_back");

    // Reset mid-vector (with in_valid and wr_en also asserted), then a write
    // issued while busy must be ignored.
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0100;
      tick();
    end
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 2'd1;
    bus.wr_data  = 16'h0000;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_state", {30'b0, state_dbg}, 32'd0);
    chk("midrst_sig_x", {22'b0, bus.sig_x}, 32'd0);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    exp_q.push_back(10'h080);
    for (int i = 0; i < NW; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0100;
      bus.wr_en    = (i == 1);
      bus.wr_addr  = 2'd3;
      bus.wr_data  = 16'h0000;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    drain("reset_and_busy_write");
    for (int t = 0; t < 5; t++) tick();

    // Randomized vectors, each run gap-free and with random gaps.
    for (int k = 0; k < 12; k++) begin
      mag = (k % 3 == 0) ? 32768 : ((k % 3 == 1) ? 512 : 256);
      for (int i = 0; i < NW; i++) begin
        rw[i] = rnd(mag);
        rx[i] = rnd(mag);
      end
      rb   = rnd(mag);
      rexp = ref_sig(rw, rb, rx);
      run_vec(rw, rb, rx, 0, rexp, $sformatf("rand%0d_nogap", k));
      run_vec(rw, rb, rx, 3, rexp, $sformatf("rand%0d_gaps", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
